// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters.
// The lookup is combinational on the fetch PC. EX resolutions train the table.
// Optional build macro PREDICTOR_STATS_EN adds the lookup and mispredict
// counters and their output ports.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    localparam int TAG_BITS  = 30 - INDEX_BITS,
    localparam int ENTRIES   = 1 << INDEX_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] pc,
    output logic [31:0] next_pc_out,
    output logic        branch_taken_out,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict
`ifdef PREDICTOR_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispredicts
`endif
);

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [1:0]          ctr_q    [ENTRIES];
    logic [1:0]          ctr_d    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [31:0]         target_d [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_BITS-1:0]   lk_tag, up_tag;
    logic                  lk_hit, up_hit, upd_en;

    assign lk_idx = pc[INDEX_BITS+1:2];
    assign lk_tag = pc[31:INDEX_BITS+2];
    assign up_idx = upd_pc[INDEX_BITS+1:2];
    assign up_tag = upd_pc[31:INDEX_BITS+2];
    // Reset takes priority, so an update in a reset cycle is dropped.
    assign upd_en = upd_valid && rdy_in && !rst_in;

    // The byte-offset bits never select an entry.
    logic unused_lowbits;
    assign unused_lowbits = ^{pc[1:0], upd_pc[1:0]};

    // Lookup reads registered state only, so an update in the same cycle is not bypassed.
    always_comb begin
        lk_hit           = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        branch_taken_out = lk_hit && ctr_q[lk_idx][1];
        next_pc_out      = branch_taken_out ? target_q[lk_idx] : pc + 32'd4;
    end

    // Training. A hit adjusts the counter. A taken miss allocates the entry,
    // evicting any other tag. A not-taken miss changes nothing.
    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        if (upd_en) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    target_d[up_idx] = upd_target;
                end else if (ctr_q[up_idx] != 2'b00) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = upd_target;
                ctr_d[up_idx]    = 2'b10;
            end
        end
    end

    // Valid bits and counters. Reset clears all history in one cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
            ctr_q   <= '{default: 2'b01};
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tags and targets have no reset. Their content is ignored while the valid bit is low.
    always_ff @(posedge clk_in) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

`ifdef PREDICTOR_STATS_EN
    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Count accepted updates and flagged mispredicts. Both wrap at 2^32.
    always_comb begin
        stat_lookups_d     = stat_lookups_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (upd_en) begin
            stat_lookups_d = stat_lookups_q + 32'd1;
            if (upd_mispredict) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    // Statistic registers, cleared by reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stat_lookups_q     <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_lookups_q     <= stat_lookups_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_lookups     = stat_lookups_q;
    assign stat_mispredicts = stat_mispredicts_q;
`else
    logic unused_mispredict;
    assign unused_mispredict = upd_mispredict;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor.
// Each vector drives one cycle of inputs. The lookup outputs are checked before
// the clock edge, so they show the state left by the previous vectors.
module tb_branch_predictor;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        um;
        logic [31:0] pc;
        logic [31:0] exp_pc;
        logic        exp_tk;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] next_pc_out;
    logic        branch_taken_out;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mispredict = 1'b0;
`ifdef PREDICTOR_STATS_EN
    logic [31:0] stat_lookups, stat_mispredicts;
`endif

    int total = 0;
    int passed = 0;
    vec_t tv[$];

    branch_predictor dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .pc(pc),
        .next_pc_out(next_pc_out), .branch_taken_out(branch_taken_out),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict)
`ifdef PREDICTOR_STATS_EN
        , .stat_lookups(stat_lookups), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Append a vector: reset, ready, update fields, lookup pc, expected outputs.
    task automatic add(input logic rst, input logic rdy, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic um,
                       input logic [31:0] lpc, input logic [31:0] epc, input logic etk);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.um = um; v.pc = lpc; v.exp_pc = epc; v.exp_tk = etk;
        tv.push_back(v);
    endtask

    // Drive a vector at the falling edge. The rising edge that follows applies its update.
    task automatic drive(input vec_t v);
        @(negedge clk_in);
        rst_in = v.rst; rdy_in = v.rdy; upd_valid = v.uv; upd_pc = v.upc;
        upd_taken = v.ut; upd_target = v.utgt; upd_mispredict = v.um; pc = v.pc;
        #1;
    endtask

    // Idle input helpers: lookup only, taken update, not-taken update.
    task automatic lk(input logic [31:0] lpc, input logic [31:0] epc, input logic etk);
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, lpc, epc, etk);
    endtask
    task automatic tk(input logic [31:0] upc, input logic [31:0] tgt,
                      input logic [31:0] lpc, input logic [31:0] epc, input logic etk);
        add(1'b0, 1'b1, 1'b1, upc, 1'b1, tgt, 1'b0, lpc, epc, etk);
    endtask
    task automatic nt(input logic [31:0] upc,
                      input logic [31:0] lpc, input logic [31:0] epc, input logic etk);
        add(1'b0, 1'b1, 1'b1, upc, 1'b0, 32'h0, 1'b0, lpc, epc, etk);
    endtask

    initial begin
        vec_t v;
        // Fresh table after reset.
        lk(32'h100, 32'h104, 1'b0);
        // First taken update allocates with ctr 10. The same-cycle lookup shows the old state.
        tk(32'h100, 32'h200, 32'h100, 32'h104, 1'b0);
        lk(32'h100, 32'h200, 1'b1);
        // Two not-taken updates: 10 -> 01 -> 00.
        nt(32'h100, 32'h100, 32'h200, 1'b1);
        nt(32'h100, 32'h100, 32'h104, 1'b0);
        lk(32'h100, 32'h104, 1'b0);
        nt(32'h100, 32'h100, 32'h104, 1'b0);          // 00 holds
        tk(32'h100, 32'h200, 32'h100, 32'h104, 1'b0); // -> 01
        lk(32'h100, 32'h104, 1'b0);
        tk(32'h100, 32'h200, 32'h100, 32'h104, 1'b0); // -> 10
        tk(32'h100, 32'h200, 32'h100, 32'h200, 1'b1); // -> 11
        tk(32'h100, 32'h240, 32'h100, 32'h200, 1'b1); // 11 holds, target -> 0x240
        nt(32'h100, 32'h100, 32'h240, 1'b1);          // -> 10, target kept
        lk(32'h100, 32'h240, 1'b1);
        // Aliasing: 0x200 maps to the same index with a different tag.
        lk(32'h200, 32'h204, 1'b0);
        nt(32'h200, 32'h100, 32'h240, 1'b1);
        lk(32'h100, 32'h240, 1'b1);
        tk(32'h200, 32'h500, 32'h200, 32'h204, 1'b0);
        lk(32'h200, 32'h500, 1'b1);
        lk(32'h100, 32'h104, 1'b0);
        // rdy_in low blocks both allocation and training.
        add(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h700, 1'b0, 32'h300, 32'h304, 1'b0);
        lk(32'h300, 32'h304, 1'b0);
        add(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h200, 32'h500, 1'b1);
        lk(32'h200, 32'h500, 1'b1);
        // Neighbouring index, independent entry.
        tk(32'h104, 32'h1000, 32'h104, 32'h108, 1'b0);
        lk(32'h104, 32'h1000, 1'b1);
        lk(32'h200, 32'h500, 1'b1);
        // Top-of-address wrap and last index.
        lk(32'hFFFF_FFFC, 32'h0, 1'b0);
        tk(32'hFFFF_FFFC, 32'h10, 32'hFFFF_FFFC, 32'h0, 1'b0);
        lk(32'hFFFF_FFFC, 32'h10, 1'b1);
        // Byte-offset bits of pc are ignored.
        lk(32'h106, 32'h1000, 1'b1);
        // Reset mid-training discards all history and wins over a same-cycle update.
        add(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104, 32'h1000, 1'b1);
        lk(32'h104, 32'h108, 1'b0);
        lk(32'h200, 32'h204, 1'b0);
        lk(32'hFFFF_FFFC, 32'h0, 1'b0);
        tk(32'h100, 32'h200, 32'h100, 32'h104, 1'b0);
        add(1'b1, 1'b1, 1'b1, 32'h104, 1'b1, 32'h900, 1'b0, 32'h100, 32'h200, 1'b1);
        lk(32'h100, 32'h104, 1'b0);
        lk(32'h104, 32'h108, 1'b0);

        // Initial reset held for 2 cycles.
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            chk($sformatf("v%0d next_pc", i), next_pc_out, tv[i].exp_pc);
            chk($sformatf("v%0d taken", i), {31'b0, branch_taken_out}, {31'b0, tv[i].exp_tk});
        end

`ifdef PREDICTOR_STATS_EN
        // Statistics: 5 accepted updates (2 mispredicts) and 1 update blocked by rdy_in.
        v = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h100, 32'h0, 1'b0};
        drive(v);
        v.rst = 1'b0; v.uv = 1'b1; v.upc = 32'h100; v.ut = 1'b1; v.utgt = 32'h200;
        for (int k = 0; k < 5; k++) begin
            v.um = (k == 1 || k == 3);
            drive(v);
        end
        v.rdy = 1'b0; v.um = 1'b1;
        drive(v);
        v.rdy = 1'b1; v.uv = 1'b0; v.um = 1'b0;
        drive(v);
        chk("stat_lookups", stat_lookups, 32'd5);
        chk("stat_mispredicts", stat_mispredicts, 32'd2);
        v.rst = 1'b1;
        drive(v);
        v.rst = 1'b0;
        drive(v);
        chk("stat_lookups_rst", stat_lookups, 32'd0);
        chk("stat_mispredicts_rst", stat_mispredicts, 32'd0);
`else
        v = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
        drive(v);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
